spi_reg_bridge: RTL

//  Command decoder behind the SPI slave, in the system-clock domain. Consumes the byte

---
 rtl/spi_reg_bridge.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// SPI command decoder: turns {rw,addr}[,wdata] byte frames into register bus strobes.
// Define SPI_REG_AUTOINC_EN for burst writes with wrapping address auto-increment.
module spi_reg_bridge #(
    parameter int               WIDTH  = 8,
    parameter int               RD_LAT = 1,
    parameter logic [WIDTH-1:0] TX_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              rx_valid,
    input  logic [WIDTH-1:0]  rx_data,
    output logic [WIDTH-1:0]  tx_data,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [WIDTH-2:0]  reg_addr,
    output logic [WIDTH-1:0]  reg_wdata,
    input  logic [WIDTH-1:0]  reg_rdata,
    output logic              frame_err
);

    localparam int ADDR_W = WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RDWAIT,
        S_WDATA,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                cs_s1_q, cs_s1_d;
    logic                cs_s2_q, cs_s2_d;
    logic                cs_s3_q, cs_s3_d;
    logic [WIDTH-1:0]    tx_q, tx_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;

    logic                start;
    logic                capture;

    assign start   = cs_s3_q & ~cs_s2_q;
    assign capture = rd_pipe_q[RD_LAT-1];

    // Next-state, strobe and data-path decode; frame start overrides the parser.
    always_comb begin
        state_d   = state_q;
        cs_s1_d   = cs_n;
        cs_s2_d   = cs_s1_q;
        cs_s3_d   = cs_s2_q;
        tx_d      = tx_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        rd_pipe_d = rd_pipe_q;

        // Read latency tracked apart from the FSM so an aborted read still lands.
        rd_pipe_d[0] = rd_en_q;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        if (capture) begin
            tx_d = reg_rdata;
            if (state_q == S_RDWAIT) begin
                state_d = S_DONE;
            end
        end

`ifdef SPI_REG_AUTOINC_EN
        if (wr_en_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
`endif

        if (start) begin
            state_d = S_CMD;
            err_d   = rx_valid;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    err_d = 1'b1;
                end
                S_CMD: begin
                    addr_d = rx_data[ADDR_W-1:0];
                    if (rx_data[WIDTH-1]) begin
                        rd_en_d = 1'b1;
                        state_d = S_RDWAIT;
                    end else begin
                        state_d = S_WDATA;
                    end
                end
                S_WDATA: begin
                    wdata_d = rx_data;
                    wr_en_d = 1'b1;
`ifdef SPI_REG_AUTOINC_EN
                    state_d = S_WDATA;
`else
                    state_d = S_DONE;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            tx_q      <= TX_RST;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            cs_s1_q   <= cs_s1_d;
            cs_s2_q   <= cs_s2_d;
            cs_s3_q   <= cs_s3_d;
            tx_q      <= tx_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    assign tx_data   = tx_q;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign frame_err = err_q;

endmodule
